// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO write-port arbiter
package fifo_arb_pkg;
  typedef enum logic {IDLE, GRANT} state_e;
  localparam int DEF_MAX_BURST = 4;
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, first requester after last_i wins
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic          valid_o,
  output logic [N-1:0]  sel_o,
  output logic [IW-1:0] idx_o
);
  int p;
  logic [N-1:0] oh;
  always_comb begin
    valid_o = |req_i;
    sel_o = '0;
    idx_o = '0;
    p = 0;
    oh = '0;
    // scan from farthest to nearest so the nearest hit after last_i is kept
    for (int k = N; k >= 1; k--) begin
      p = (int'(last_i) + k) % N;
      oh = N'(1) << p;
      if (|(req_i & oh)) begin
        sel_o = oh;
        idx_o = IW'(p);
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing the async FIFO write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_SIZE = 8,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                         wclk,
  input  logic                         wrst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  input  logic                         wfull,
  output logic                         winc,
  output logic [DATA_SIZE-1:0]         wdata,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_REQ-1:0]           ack,
  output logic                         busy
);
  localparam int IW = clog2(NUM_REQ);
  localparam int CW = clog2(MAX_BURST) + 1;
  state_e state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0] owner_q, owner_d, last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pick_valid, own_req, last_word;
  logic [NUM_REQ-1:0] pick_sel;
  logic [IW-1:0] pick_idx;
  logic [DATA_SIZE-1:0] own_data;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i  (req),
    .last_i (last_q),
    .valid_o(pick_valid),
    .sel_o  (pick_sel),
    .idx_o  (pick_idx)
  );

  always_comb begin
    own_req = 1'b0;
    own_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IW'(i)) begin
        own_req = req[i];
        own_data = req_data[i*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  assign busy = state_q == GRANT;
  assign winc = busy & own_req & ~wfull;
  assign wdata = busy ? own_data : '0;
  assign gnt = gnt_q;
  assign ack = gnt_q & {NUM_REQ{winc}};
  assign last_word = cnt_q == CW'(MAX_BURST - 1);

  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    owner_d = owner_q;
    last_d = last_q;
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      if (pick_valid) begin
        state_d = GRANT;
        gnt_d = pick_sel;
        owner_d = pick_idx;
        cnt_d = '0;
      end
    end else if (!own_req || (winc && last_word)) begin
      state_d = IDLE;
      gnt_d = '0;
      last_d = owner_q;
    end else if (winc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      gnt_q <= '0;
      owner_q <= '0;
      last_q <= IW'(NUM_REQ - 1);
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      owner_q <= owner_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed tables, hand sequences and random traffic vs a burst-level model
module tb_fifo_wr_arbiter;
  localparam int N = 4, D = 8, MB = 4;
  logic wclk = 1'b0, wrst_n, wfull, winc, busy;
  logic [N-1:0] req, gnt, ack;
  logic [N*D-1:0] req_data;
  logic [D-1:0] wdata;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_SIZE(D), .MAX_BURST(MB)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data), .wfull(wfull),
    .winc(winc), .wdata(wdata), .gnt(gnt), .ack(ack), .busy(busy)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic [3:0] req;
    logic       wfull;
    logic [3:0] gnt;
    logic       winc;
    logic [7:0] wdata;
  } vec_t;
  vec_t tbl[$];

  int n_tests = 0, n_fail = 0;
  int cnt[N];
  int m_owner, m_last, m_left;
  logic e_winc, e_busy, s_winc, s_busy;
  logic [D-1:0] e_wdata, s_wdata;
  logic [N-1:0] e_gnt, e_ack, s_gnt, s_ack;

  function automatic logic [D-1:0] word(input int i, input int n);
    return D'(8'h90 + 16 * i + n);
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  task automatic drive_data();
    for (int i = 0; i < N; i++) req_data[i*D +: D] = word(i, cnt[i]);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last = N - 1;
    m_left = 0;
  endtask

  task automatic model_eval();
    e_busy = m_owner >= 0;
    e_gnt = '0;
    e_winc = 1'b0;
    e_wdata = '0;
    if (e_busy) begin
      e_gnt = N'(1) << m_owner;
      e_winc = req[m_owner] && !wfull;
      e_wdata = word(m_owner, cnt[m_owner]);
    end
    e_ack = e_winc ? e_gnt : '0;
  endtask

  task automatic model_clock();
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (req[(m_last + k) % N]) begin
          m_owner = (m_last + k) % N;
          m_left = MB;
          break;
        end
      end
    end else begin
      if (e_winc) m_left--;
      if (!req[m_owner] || m_left == 0) begin
        m_last = m_owner;
        m_owner = -1;
      end
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic f);
    req = r;
    wfull = f;
    drive_data();
    @(negedge wclk);
    s_gnt = gnt; s_winc = winc; s_wdata = wdata; s_ack = ack; s_busy = busy;
    model_eval();
    chk("gnt", s_gnt, e_gnt);
    chk("winc", s_winc, e_winc);
    chk("wdata", s_wdata, e_wdata);
    chk("ack", s_ack, e_ack);
    chk("busy", s_busy, e_busy);
    chk("gnt_onehot0", $onehot0(s_gnt), 1);
    chk("ack_subset", s_ack & ~s_gnt, 0);
    chk("winc_not_full", s_winc & wfull, 0);
    @(posedge wclk);
    model_clock();
    for (int i = 0; i < N; i++) if (s_ack[i]) cnt[i]++;
    #1;
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    req = '0;
    wfull = 1'b0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    drive_data();
    model_reset();
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_winc", winc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wdata", wdata, 0);
    repeat (2) @(posedge wclk);
    #1 wrst_n = 1'b1;
  endtask

  task automatic add(input logic [3:0] r, input logic f, input logic [3:0] g, input logic w, input logic [7:0] d);
    tbl.push_back('{r, f, g, w, d});
  endtask

  initial begin
    add(4'h2, 0, 4'h0, 0, 8'h00);
    add(4'h2, 0, 4'h2, 1, 8'hA0); add(4'h2, 0, 4'h2, 1, 8'hA1);
    add(4'h2, 0, 4'h2, 1, 8'hA2); add(4'h2, 0, 4'h2, 1, 8'hA3);
    add(4'h2, 0, 4'h0, 0, 8'h00);
    add(4'h2, 0, 4'h2, 1, 8'hA4); add(4'h2, 0, 4'h2, 1, 8'hA5);
    add(4'h0, 0, 4'h2, 0, 8'hA6); add(4'h0, 0, 4'h0, 0, 8'h00);
    add(4'h4, 0, 4'h0, 0, 8'h00);
    add(4'h4, 0, 4'h4, 1, 8'hB0); add(4'h4, 0, 4'h4, 1, 8'hB1);
    for (int i = 0; i < 5; i++) add(4'h4, 1, 4'h4, 0, 8'hB2);
    add(4'h4, 0, 4'h4, 1, 8'hB2); add(4'h4, 0, 4'h4, 1, 8'hB3);
    add(4'h0, 0, 4'h0, 0, 8'h00);
    add(4'h9, 0, 4'h0, 0, 8'h00); add(4'h9, 0, 4'h8, 1, 8'hC0);
    add(4'h1, 0, 4'h8, 0, 8'hC1); add(4'h1, 0, 4'h0, 0, 8'h00);
    add(4'h1, 0, 4'h1, 1, 8'h90); add(4'h0, 0, 4'h1, 0, 8'h91);
    add(4'h0, 0, 4'h0, 0, 8'h00);

    do_reset();
    for (int v = 0; v < tbl.size(); v++) begin
      step(tbl[v].req, tbl[v].wfull);
      chk($sformatf("tbl%0d_gnt", v), s_gnt, tbl[v].gnt);
      chk($sformatf("tbl%0d_winc", v), s_winc, tbl[v].winc);
      chk($sformatf("tbl%0d_wdata", v), s_wdata, tbl[v].wdata);
      chk($sformatf("tbl%0d_busy", v), s_busy, tbl[v].gnt != 0);
    end

    begin : rr
      int ord[$];
      int ac[N];
      int wr;
      logic [N-1:0] pg;
      do_reset();
      wr = 0;
      pg = '0;
      for (int i = 0; i < N; i++) ac[i] = 0;
      for (int c = 0; c < 22; c++) begin
        step(4'hF, 1'b0);
        if (s_gnt != 0 && pg == 0) ord.push_back($clog2(s_gnt));
        if (s_winc && wr < 16) begin
          wr++;
          for (int i = 0; i < N; i++) if (s_ack[i]) ac[i]++;
        end
        pg = s_gnt;
      end
      chk("rr_ngrants", ord.size(), 5);
      for (int i = 0; i < 5; i++) chk($sformatf("rr_order%0d", i), (i < ord.size()) ? ord[i] : -1, i % N);
      chk("rr_writes", wr, 16);
      for (int i = 0; i < N; i++) chk($sformatf("rr_acks%0d", i), ac[i], 4);
    end

    do_reset();
    step(4'h1, 1'b0);
    step(4'h1, 1'b0);
    #1;
    chk("mid_live_winc", winc, 1);
    wrst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_winc", winc, 0);
    chk("mid_rst_busy", busy, 0);
    model_reset();
    @(posedge wclk);
    #1 wrst_n = 1'b1;
    step(4'hF, 1'b0);
    chk("post_rst_idle", s_gnt, 0);
    step(4'hF, 1'b0);
    chk("post_rst_gnt", s_gnt, 4'h1);
    chk("post_rst_wdata", s_wdata, 8'h91);

    begin : rnd
      logic [N-1:0] req_v;
      do_reset();
      req_v = '0;
      s_ack = '0;
      for (int c = 0; c < 3000; c++) begin
        for (int i = 0; i < N; i++) begin
          if (s_ack[i]) req_v[i] = ($urandom % 4) != 0;
          else if (!req_v[i]) req_v[i] = ($urandom % 3) == 0;
          else if (($urandom % 24) == 0) req_v[i] = 1'b0;
        end
        step(req_v, ($urandom % 4) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
